seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Downstream display stage for the MIPS system's debug output. Accepts a 32-bit value selected by the system's output-select logic and converts it to decimal with a sequential double-dabble engine. It then time-multiplexes the result onto an 8-digit common-anode seven-segment display with leading-zero blanking. It frees the core from any display timing and holds the last shown value until a new one is accepted.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays lit; legal range 2..65535.
- DIGITS, 8: number of display digits; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  32  binary value to display.
- value_valid  in  1  value is presented this cycle.
- value_ready  out  1  block can accept a value this cycle.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit anodes, active-low, one-hot-low; bit 0 is the rightmost digit.
- busy  out  1  conversion in progress.
- ovf  out  1  last accepted value exceeded 99,999,999.

## Operation
- FSM states:
  - IDLE to CONV on value_valid && value_ready; value is captured.
  - CONV runs exactly 32 shift iterations (add-3 then shift), one per cycle.
  - CONV to LOAD after the 32nd iteration.
  - LOAD to IDLE after one cycle.
- value_ready = (state == IDLE). busy = (state != IDLE).
- Conversion produces 10 BCD digits. The low 8 digits feed the display.
- ovf is set in LOAD if either upper BCD digit is nonzero. It is cleared in LOAD otherwise.
- Display digit registers update only in LOAD, all 8 at once. The scanner never shows a partial result.
- Leading-zero blanking: digit i is blank (seg = 7'h7F) if it and every higher digit are zero, for i ≥ 1. Digit 0 always shows, so a value of 0 displays "0".
- Scanner:
  - A 16-bit counter counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances; 7 wraps to 0.
  - an[idx] is low; all other anodes are high.
  - The scanner runs continuously in every FSM state and is independent of the conversion.
- value_valid while not ready: ignored. The source must hold it until accepted.
- A value accepted in the same cycle LOAD completes is impossible, because ready is low in LOAD.

## Timing
- Reset values:
  - seg = 7'h7F, an = 8'hFE (digit 0 selected).
  - Display digit registers = 0 with all blanked except digit 0, so digit 0 shows "0".
  - value_ready = 1, busy = 0, ovf = 0.
  - FSM in IDLE; scan counter and digit index = 0.
- Latency: acceptance at edge N; display registers and ovf valid after edge N+33. value_ready is high again after edge N+34.
- Reset asserted mid-conversion aborts immediately and returns all reset values. The prior display contents are lost.
- seg and an are registered. They change only on the scanner's terminal-count edge or the LOAD edge, so there is no combinational glitching on the pins.

## Configuration
- SEG_DECIMAL_EN defined: the behaviour described above (binary to BCD, leading-zero blanking, ovf).
- SEG_DECIMAL_EN undefined:
  - The conversion engine is not built.
  - value is shown as 8 hex nibbles, encoding 0-9 and A b C d E F.
  - Latency is 1 cycle: accept, then LOAD.
  - Leading-zero blanking still applies.
  - ovf is tied to 0.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry seven-segment encoding constant array (active-low);
  - the blank constant 7'h7F;
  - the FSM state enum {IDLE, CONV, LOAD};
  - the DIGITS constant.
- The natural sub-module is bin2bcd_seq: a 32-bit to 40-bit BCD engine with start/done handshake, instantiated only under SEG_DECIMAL_EN.
- Scanner, blanking and FSM sit in the top module.

## Test plan
All scenarios run with SCAN_DIV = 4.
- Reset, no input: an cycles FE, FD, FB … 7F, FE every 4 clocks. seg = 7'h40 ("0") on digit 0 and 7'h7F on all others.
- Accept value 140: busy for 34 cycles, value_ready low throughout. The display then shows "140" on digits 2..0, digits 7..3 blank, ovf = 0.
- Accept 32'hFFFFFFFF: digits read 94967295 and ovf = 1. A following value of 5 clears ovf and displays "5".
- value_valid held high during CONV with a different value: the value is not captured. It is accepted on the first IDLE cycle, and the display reflects each value in order.
- Assert reset at cycle 10 of a conversion of 12345678: all outputs return to their reset values, and the next accept proceeds normally.
- SEG_DECIMAL_EN undefined, value 32'h00C0FFEE: after 2 cycles the display shows "C0FFEE" with the top 2 digits blank.

Source files
------------

// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | seg_pkg : shared constants, segment encoding and FSM state type for the    |
// |           seven-segment scan display. Revision 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F
  localparam logic [0:15][6:0] SEG_LUT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_display_scan_bin2bcd_seq.sv
// +----------------------------------------------------------------------------+
// | bin2bcd_seq : sequential 32-bit binary to 10-digit BCD converter           |
// |               (double dabble, one shift per clock). Built only when        |
// |               SEG_DECIMAL_EN is defined. Revision 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef SEG_DECIMAL_EN
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic        done_o,
  output logic [39:0] bcd_o
);

  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [39:0] adj_d;
  logic [71:0] shift_d;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic        done_q;

  always_comb begin
    adj_d = bcd_q;
    for (int d = 0; d < 10; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
    shift_d = {adj_d, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q <= bin_i;
        bcd_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= shift_d[71:32];
        bin_q <= shift_d[31:0];
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule
`endif

`default_nettype wire

// File: rtl/seg_display_scan.sv
// +----------------------------------------------------------------------------+
// | seg_display_scan : accepts a 32-bit value, converts it (decimal when       |
// |   SEG_DECIMAL_EN is defined, hex otherwise) and scans it onto an 8-digit   |
// |   common-anode display with leading-zero blanking. Revision 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_display_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       value,
  input  logic              value_valid,
  output logic              value_ready,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf
);

  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  state_t              state_q;
  logic                ready_q;
  logic                busy_q;
  logic [4*DIGITS-1:0] disp_q;
  logic [4*DIGITS-1:0] disp_d;
  logic                load_en;
  logic [4*DIGITS-1:0] load_val;
  logic                accept;

  logic [15:0]         cnt_q;
  logic [15:0]         cnt_d;
  logic [2:0]          idx_q;
  logic [2:0]          idx_d;
  logic [DIGITS-1:0]   an_q;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_q;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   blank_d;
  logic                zero_run;
  logic                scan_tc;

  assign accept = value_valid && ready_q;

`ifdef SEG_DECIMAL_EN
  logic        bcd_done;
  logic [39:0] bcd;
  logic        ovf_q;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept),
    .bin_i   (value),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  assign load_en  = (state_q == CONV) && bcd_done;
  assign load_val = bcd[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (load_en) begin
      ovf_q <= |bcd[39:32];
    end
  end

  assign ovf = ovf_q;
`else
  logic [31:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (accept) begin
      value_q <= value;
    end
  end

  assign load_en  = (state_q == CONV);
  assign load_val = value_q;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      disp_q <= disp_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= CONV;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          if (load_en) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_tc = (cnt_q == SCAN_TC);

  // seg is computed from the post-edge digit and display contents so a LOAD
  // and a digit advance land on the pins in the same clock as the registers.
  always_comb begin
    disp_d   = load_en ? load_val : disp_q;
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
    cnt_d = scan_tc ? 16'd0 : cnt_q + 16'd1;
    idx_d = scan_tc ? idx_q + 3'd1 : idx_q;
    an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
    seg_d = blank_d[idx_d] ? SEG_BLANK : seg_encode(disp_d[{idx_d, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign value_ready = ready_q;
  assign busy        = busy_q;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scan.sv
// +----------------------------------------------------------------------------+
// | tb_seg_display_scan : self-checking bench for seg_display_scan with a      |
// |   digit/blanking reference model (decimal or hex per SEG_DECIMAL_EN).      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_display_scan;

  localparam int SD = 4;
`ifdef SEG_DECIMAL_EN
  localparam bit DEC    = 1'b1;
  localparam int LAT    = 33;
  localparam int RST_AT = 10;
`else
  localparam bit DEC    = 1'b0;
  localparam int LAT    = 1;
  localparam int RST_AT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        busy;
  logic        ovf;

  int          errors = 0;
  int          checks = 0;
  int unsigned e = 0;
  logic [31:0] shown = '0;
  logic        shown_ovf = 1'b0;

  logic [6:0] segt [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_display_scan #(.SCAN_DIV(SD), .DIGITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg         (seg),
    .an          (an),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released; drives the expected digit index.
  always @(posedge clk or posedge reset) begin
    if (reset) e <= 0;
    else       e <= e + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [31:0] v, input int i);
    longint unsigned m, base, p;
    m    = DEC ? (longint'(v) % 100000000) : longint'(v);
    base = DEC ? 10 : 16;
    p    = 1;
    for (int k = 0; k < i; k++) p = p * base;
    if (i >= 1 && m < p) return 7'h7F;
    return segt[int'((m / p) % base)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    int         idx;
    logic [7:0] ea;
    idx = int'((e / SD) % 8);
    ea  = ~(8'd1 << idx);
    check({tag, "_an"}, {24'd0, an}, {24'd0, ea});
    check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(shown, idx)});
  endtask

  task automatic scan(input string tag);
    repeat (8 * SD) begin
      @(negedge clk);
      check_now(tag);
    end
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, shown_ovf});
  endtask

  task automatic accept(input logic [31:0] v);
    int n;
    n = 0;
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    while (value_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, value_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Called at the first falling edge after the accepting rising edge.
  task automatic wait_conv(input logic [31:0] v);
    int b;
    b = 0;
    while (busy === 1'b1 && b < 100) begin
      b++;
      check("ready_low", {31'd0, value_ready}, 32'd0);
      if (b == LAT) check_now("preload");
      if (b == LAT + 1) begin
        shown     = v;
        shown_ovf = DEC && (v > 32'd99999999);
        check("load_ovf", {31'd0, ovf}, {31'd0, shown_ovf});
        check_now("load");
      end
      @(negedge clk);
    end
    check("busy_len", b, LAT + 1);
    shown     = v;
    shown_ovf = DEC && (v > 32'd99999999);
  endtask

  task automatic send(input logic [31:0] v);
    accept(v);
    @(negedge clk);
    value_valid = 1'b0;
    wait_conv(v);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"},   {25'd0, seg}, 32'h7F);
    check({tag, "_an"},    {24'd0, an}, 32'hFE);
    check({tag, "_ready"}, {31'd0, value_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_ovf"},   {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, v;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk);
    scan("idle0");

    send(32'd140);
    scan("v140");
    send(32'hFFFF_FFFF);
    scan("vmax");
    send(32'd5);
    scan("v5");

    // value_valid held through a conversion with a different value behind it
    a = 32'd777;
    b = DEC ? 32'd12 : 32'h0000_BEEF;
    accept(a);
    @(negedge clk);
    value = b;
    wait_conv(a);
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    wait_conv(b);
    scan("hold");

    // Reset partway through a conversion
    accept(32'd12345678);
    @(negedge clk);
    value_valid = 1'b0;
    repeat (RST_AT - 1) @(negedge clk);
    check("midconv_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    shown     = '0;
    shown_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    scan("postrst");

    send(32'd0);
    scan("v0");
    send(32'h00C0_FFEE);
    scan("coffee");

    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        default: v = $urandom_range(0, 9999);
      endcase
      send(v);
      scan("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
